// File: rtl/ysyx_22040386_pkg.sv
// Shared write-back types: GPR index/data widths and the result request
// struct that EXU and LSU hand to the write-back unit.
package ysyx_22040386_pkg;

  localparam int GPR_ADDR_W = 5;
  localparam int XLEN       = 64;
  localparam int NUM_GPR    = 1 << GPR_ADDR_W;

  typedef logic [GPR_ADDR_W-1:0] gpr_idx_t;
  typedef logic [XLEN-1:0]       xlen_t;

  typedef struct packed {
    gpr_idx_t rd;
    xlen_t    wdata;
  } wb_req_t;

endpackage

// File: rtl/ysyx_22040386_scoreboard.sv
// Per-GPR busy scoreboard. A bit is set when decode issues a writer of that
// register and cleared when the register file write for it is presented.
// x0 is never marked busy. Two query ports serve decode's rs1/rs2 lookups;
// the full vector is exported for the issue and error checks.
module ysyx_22040386_scoreboard
  import ysyx_22040386_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  set_en,
  input  logic [GPR_ADDR_W-1:0] set_idx,
  input  logic                  clr_en,
  input  logic [GPR_ADDR_W-1:0] clr_idx,
  input  logic [GPR_ADDR_W-1:0] q1_idx,
  input  logic [GPR_ADDR_W-1:0] q2_idx,
  output logic                  q1_busy,
  output logic                  q2_busy,
  output logic [NUM_GPR-1:0]    busy
);

  logic [NUM_GPR-1:0] busy_q;

  // Busy bits: clear on write-back, set on issue; different indices may do both at once
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      if (clr_en) begin
        busy_q[clr_idx] <= 1'b0;
      end
      if (set_en && (set_idx != '0)) begin
        busy_q[set_idx] <= 1'b1;
      end
    end
  end

  assign busy    = busy_q;
  assign q1_busy = busy_q[q1_idx];
  assign q2_busy = busy_q[q2_idx];

endmodule

// File: rtl/ysyx_22040386_wbu.sv
// Write-back unit: arbitrates LSU (priority) and EXU results onto the single
// GPR write port through one register stage, and tracks pending writes so
// decode can stall on RAW/WAW hazards.
// Optional feature macro: YSYX_22040386_WB_BYPASS_EN adds a forwarding path
// from the registered write port to the rs1/rs2 queries.
module ysyx_22040386_wbu
  import ysyx_22040386_pkg::*;
#(
  parameter int ADDR_WIDTH = GPR_ADDR_W,
  parameter int DATA_WIDTH = XLEN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  iss_valid,
  output logic                  iss_ready,
  input  logic [ADDR_WIDTH-1:0] iss_rd,
  input  logic                  exu_valid,
  output logic                  exu_ready,
  input  logic [ADDR_WIDTH-1:0] exu_rd,
  input  logic [DATA_WIDTH-1:0] exu_wdata,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_wdata,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  wb_err
`ifdef YSYX_22040386_WB_BYPASS_EN
  ,
  output logic                  rs1_byp_valid,
  output logic                  rs2_byp_valid,
  output logic [DATA_WIDTH-1:0] rs1_byp_data,
  output logic [DATA_WIDTH-1:0] rs2_byp_data
`endif
);

  wb_req_t            win_req;
  logic               accept;
  logic               win_busy;
  logic               rs1_busy_raw;
  logic               rs2_busy_raw;
  logic [NUM_GPR-1:0] busy_vec;

  // LSU always wins; EXU is only taken when no load result competes
  assign lsu_ready = 1'b1;
  assign exu_ready = !lsu_valid;
  assign accept    = lsu_valid || exu_valid;

  // Select the winning result
  always_comb begin
    win_req = '{rd: exu_rd, wdata: exu_wdata};
    if (lsu_valid) begin
      win_req = '{rd: lsu_rd, wdata: lsu_wdata};
    end
  end

  assign win_busy  = busy_vec[win_req.rd];
  assign iss_ready = !busy_vec[iss_rd];

  ysyx_22040386_scoreboard u_scoreboard (
    .clk     (clk),
    .rst_n   (rst_n),
    .set_en  (iss_valid && iss_ready),
    .set_idx (iss_rd),
    .clr_en  (rf_wen),
    .clr_idx (rf_waddr),
    .q1_idx  (rs1_addr),
    .q2_idx  (rs2_addr),
    .q1_busy (rs1_busy_raw),
    .q2_busy (rs2_busy_raw),
    .busy    (busy_vec)
  );

  // Register the accepted result onto the RF port; x0 writes never assert rf_wen
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      wb_err   <= 1'b0;
    end else begin
      rf_wen <= accept && (win_req.rd != '0);
      if (accept) begin
        rf_waddr <= win_req.rd;
        rf_wdata <= win_req.wdata;
      end
      if (accept && (win_req.rd != '0) && !win_busy) begin
        wb_err <= 1'b1;
      end
    end
  end

`ifdef YSYX_22040386_WB_BYPASS_EN
  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit       = rf_wen && (rf_waddr == rs1_addr);
  assign rs2_hit       = rf_wen && (rf_waddr == rs2_addr);
  assign rs1_busy      = rs1_busy_raw && !rs1_hit;
  assign rs2_busy      = rs2_busy_raw && !rs2_hit;
  assign rs1_byp_valid = rs1_hit;
  assign rs2_byp_valid = rs2_hit;
  assign rs1_byp_data  = rf_wdata;
  assign rs2_byp_data  = rf_wdata;
`else
  assign rs1_busy = rs1_busy_raw;
  assign rs2_busy = rs2_busy_raw;
`endif

endmodule

// File: tb/tb_ysyx_22040386_wbu.sv
// Self-checking bench for the write-back unit: directed scenarios with
// literal expectations followed by randomized traffic against a
// behavioural model of the register write port and pending-write set.
module tb_ysyx_22040386_wbu;

  logic        clk;
  logic        rst_n;
  logic        iss_valid;
  logic        iss_ready;
  logic [4:0]  iss_rd;
  logic        exu_valid;
  logic        exu_ready;
  logic [4:0]  exu_rd;
  logic [63:0] exu_wdata;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [63:0] lsu_wdata;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        wb_err;
`ifdef YSYX_22040386_WB_BYPASS_EN
  logic        rs1_byp_valid;
  logic        rs2_byp_valid;
  logic [63:0] rs1_byp_data;
  logic [63:0] rs2_byp_data;
`endif

  int n_checks = 0;
  int n_errors = 0;
  bit check_en = 0;

  // Model state: which registers have an outstanding write, what sits on the RF port
  bit          m_busy [32];
  bit          m_wen;
  logic [4:0]  m_waddr;
  logic [63:0] m_wdata;
  bit          m_err;
  int          pending[$];

  ysyx_22040386_wbu dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .iss_valid (iss_valid),
    .iss_ready (iss_ready),
    .iss_rd    (iss_rd),
    .exu_valid (exu_valid),
    .exu_ready (exu_ready),
    .exu_rd    (exu_rd),
    .exu_wdata (exu_wdata),
    .lsu_valid (lsu_valid),
    .lsu_ready (lsu_ready),
    .lsu_rd    (lsu_rd),
    .lsu_wdata (lsu_wdata),
    .rf_wen    (rf_wen),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rs1_busy  (rs1_busy),
    .rs2_busy  (rs2_busy),
    .wb_err    (wb_err)
`ifdef YSYX_22040386_WB_BYPASS_EN
    ,
    .rs1_byp_valid (rs1_byp_valid),
    .rs2_byp_valid (rs2_byp_valid),
    .rs1_byp_data  (rs1_byp_data),
    .rs2_byp_data  (rs2_byp_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rn,
                               input logic iv, input logic [4:0] ird,
                               input logic ev, input logic [4:0] erd, input logic [63:0] ed,
                               input logic lv, input logic [4:0] lrd, input logic [63:0] ld,
                               input logic [4:0] r1, input logic [4:0] r2);
    rst_n     = rn;
    iss_valid = iv;  iss_rd = ird;
    exu_valid = ev;  exu_rd = erd;  exu_wdata = ed;
    lsu_valid = lv;  lsu_rd = lrd;  lsu_wdata = ld;
    rs1_addr  = r1;  rs2_addr = r2;
  endtask

  task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
    applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, r1, r2);
  endtask

  // Advance the model by one clock using the inputs the DUT just sampled
  task automatic modelStep();
    bit          old_busy [32];
    bit          acc;
    logic [4:0]  rd;
    logic [63:0] data;
    bit          old_wen;
    logic [4:0]  old_waddr;
    if (!rst_n) begin
      foreach (m_busy[i]) m_busy[i] = 0;
      m_wen = 0; m_waddr = '0; m_wdata = '0; m_err = 0;
      pending.delete();
      return;
    end
    old_busy  = m_busy;
    old_wen   = m_wen;
    old_waddr = m_waddr;
    acc  = lsu_valid || exu_valid;
    rd   = lsu_valid ? lsu_rd : exu_rd;
    data = lsu_valid ? lsu_wdata : exu_wdata;
    if (acc) begin
      if (rd != 0 && !old_busy[rd]) m_err = 1;
      m_waddr = rd;
      m_wdata = data;
      for (int i = 0; i < pending.size(); i++) begin
        if (pending[i] == int'(rd)) begin
          pending.delete(i);
          break;
        end
      end
    end
    if (old_wen) m_busy[old_waddr] = 0;
    if (iss_valid && iss_rd != 0 && !old_busy[iss_rd]) begin
      m_busy[iss_rd] = 1;
      pending.push_back(int'(iss_rd));
    end
    m_wen = acc && (rd != 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    modelStep();
  endtask

  function automatic bit expRsBusy(input logic [4:0] rs);
`ifdef YSYX_22040386_WB_BYPASS_EN
    return m_busy[rs] && !(m_wen && m_waddr == rs);
`else
    return m_busy[rs];
`endif
  endfunction

  task automatic checkOutput();
    chk("rf_wen",    rf_wen,    m_wen);
    chk("rf_waddr",  rf_waddr,  m_waddr);
    chk("rf_wdata",  rf_wdata,  m_wdata);
    chk("wb_err",    wb_err,    m_err);
    chk("iss_ready", iss_ready, !m_busy[iss_rd]);
    chk("lsu_ready", lsu_ready, 1'b1);
    chk("exu_ready", exu_ready, !lsu_valid);
    chk("rs1_busy",  rs1_busy,  expRsBusy(rs1_addr));
    chk("rs2_busy",  rs2_busy,  expRsBusy(rs2_addr));
`ifdef YSYX_22040386_WB_BYPASS_EN
    chk("rs1_byp_valid", rs1_byp_valid, m_wen && m_waddr == rs1_addr);
    chk("rs2_byp_valid", rs2_byp_valid, m_wen && m_waddr == rs2_addr);
    if (m_wen && m_waddr == rs1_addr) chk("rs1_byp_data", rs1_byp_data, m_wdata);
    if (m_wen && m_waddr == rs2_addr) chk("rs2_byp_data", rs2_byp_data, m_wdata);
`endif
  endtask

  // Compare process: every cycle, mid-period, DUT versus model
  always @(negedge clk) begin
    if (check_en) checkOutput();
  end

  initial begin
    logic [4:0] erd;
    logic [4:0] lrd;
    logic       ev;
    logic       lv;
    int         ie;
    int         il;

    $display("[TB] write-back unit bench start");

    // Reset held two cycles with every valid high
    applyStimulus(1'b0, 1'b1, 5'd5, 1'b1, 5'd9, 64'h11, 1'b1, 5'd10, 64'h22, 5'd5, 5'd0);
    tick();
    check_en = 1;
    tick();
    chk("reset_rf_wen", rf_wen, 1'b0);
    chk("reset_wb_err", wb_err, 1'b0);
    chk("reset_rs1_busy", rs1_busy, 1'b0);
    idle(5'd5, 5'd0);
    tick();

    // Basic write: issue rd5 then EXU result 0x1234
    applyStimulus(1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 5'd5, 5'd0);
    tick();
    chk("basic_busy_after_issue", rs1_busy, 1'b1);
    applyStimulus(1'b1, 1'b0, 5'd0, 1'b1, 5'd5, 64'h1234, 1'b0, 5'd0, 64'd0, 5'd5, 5'd0);
    tick();
    chk("basic_rf_wen", rf_wen, 1'b1);
    chk("basic_rf_waddr", rf_waddr, 5'd5);
    chk("basic_rf_wdata", rf_wdata, 64'h1234);
`ifndef YSYX_22040386_WB_BYPASS_EN
    chk("basic_busy_during_wb", rs1_busy, 1'b1);
`endif
    idle(5'd5, 5'd0);
    tick();
    chk("basic_rf_wen_drop", rf_wen, 1'b0);
    chk("basic_busy_cleared", rs1_busy, 1'b0);
    chk("basic_waddr_hold", rf_waddr, 5'd5);

    // Collision: EXU rd3 and LSU rd4 together, LSU first
    applyStimulus(1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 5'd3, 5'd4);
    tick();
    applyStimulus(1'b1, 1'b1, 5'd4, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 5'd3, 5'd4);
    tick();
    applyStimulus(1'b1, 1'b0, 5'd0, 1'b1, 5'd3, 64'hAAAA, 1'b1, 5'd4, 64'hBBBB, 5'd3, 5'd4);
    #1;
    chk("coll_lsu_ready", lsu_ready, 1'b1);
    chk("coll_exu_ready", exu_ready, 1'b0);
    tick();
    chk("coll_first_waddr", rf_waddr, 5'd4);
    chk("coll_first_wdata", rf_wdata, 64'hBBBB);
    applyStimulus(1'b1, 1'b0, 5'd0, 1'b1, 5'd3, 64'hAAAA, 1'b0, 5'd0, 64'd0, 5'd3, 5'd4);
    tick();
    chk("coll_second_wen", rf_wen, 1'b1);
    chk("coll_second_waddr", rf_waddr, 5'd3);
    chk("coll_second_wdata", rf_wdata, 64'hAAAA);
    idle(5'd3, 5'd4);
    tick();

    // WAW stall: rd7 issued twice back-to-back
    applyStimulus(1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 5'd7, 5'd0);
    tick();
    applyStimulus(1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 5'd7, 5'd0);
    #1;
    chk("waw_stall", iss_ready, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b1, 5'd7, 1'b1, 5'd7, 64'h77, 1'b0, 5'd0, 64'd0, 5'd7, 5'd0);
    tick();
    chk("waw_stall_during_wb", iss_ready, 1'b0);
    applyStimulus(1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 5'd7, 5'd0);
    tick();
    chk("waw_release", iss_ready, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b0, 5'd0, 1'b1, 5'd7, 64'h78, 1'b0, 5'd0, 64'd0, 5'd7, 5'd0);
    tick();
    idle(5'd7, 5'd0);
    tick();
    tick();

    // Randomized traffic; results only target outstanding registers (or x0)
    for (int cyc = 0; cyc < 3000; cyc++) begin
      ev = 0; lv = 0; erd = '0; lrd = '0; ie = -1; il = -1;
      if (pending.size() > 0 && $urandom_range(0, 2) != 0) begin
        ie = $urandom_range(0, pending.size() - 1);
        ev = 1; erd = 5'(pending[ie]);
      end
      if (pending.size() > 1 && $urandom_range(0, 2) == 0) begin
        il = $urandom_range(0, pending.size() - 1);
        if (il != ie) begin
          lv = 1; lrd = 5'(pending[il]);
        end
      end
      if (!ev && $urandom_range(0, 15) == 0) begin
        ev = 1; erd = 5'd0;
      end
      applyStimulus(($urandom_range(0, 299) != 0),
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                    ev, erd, {$urandom, $urandom},
                    lv, lrd, {$urandom, $urandom},
                    5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      tick();
    end

    // Reset mid-operation, then x0 write and unissued-destination error
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 5'd9, 5'd0);
    tick();
    idle(5'd9, 5'd0);
    tick();
    applyStimulus(1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 64'hDEAD, 1'b0, 5'd0, 64'd0, 5'd9, 5'd0);
    tick();
    chk("x0_rf_wen", rf_wen, 1'b0);
    chk("x0_wb_err", wb_err, 1'b0);
    applyStimulus(1'b1, 1'b0, 5'd0, 1'b1, 5'd9, 64'h9999, 1'b0, 5'd0, 64'd0, 5'd9, 5'd0);
    tick();
    chk("err_set", wb_err, 1'b1);
    idle(5'd9, 5'd0);
    tick();
    tick();
    chk("err_sticky", wb_err, 1'b1);

`ifdef YSYX_22040386_WB_BYPASS_EN
    // Bypass: write of rd6 visible as forwarded data rather than busy
    applyStimulus(1'b1, 1'b1, 5'd6, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 5'd0, 5'd6);
    tick();
    applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd6, 64'h6666, 5'd0, 5'd6);
    tick();
    chk("byp_rs2_busy", rs2_busy, 1'b0);
    chk("byp_rs2_valid", rs2_byp_valid, 1'b1);
    chk("byp_rs2_data", rs2_byp_data, 64'h6666);
    idle(5'd0, 5'd6);
    tick();
`endif

    @(negedge clk);
    #1;
    check_en = 0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
